// File: rtl/mob_pkg.sv
// rtl/mob_pkg.sv - shared state type, depth constant and dimension check for mat_operand_buffer
package mob_pkg;

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, STREAM, DONE} state_t;

   localparam int N_DEF     = 3;
   localparam int DEPTH_DEF = N_DEF * N_DEF;

   // A product W*X is only legal when every dimension fits the storage and the inner dimensions agree.
   function automatic logic dims_err(input int unsigned rw, input int unsigned cw,
                                     input int unsigned rx, input int unsigned cx,
                                     input int unsigned n);
      return (rw == 0) || (cw == 0) || (rx == 0) || (cx == 0) ||
             (rw > n) || (cw > n) || (rx > n) || (cx > n) || (cw != rx);
   endfunction

endpackage

// File: rtl/mob_mat_store.sv
// rtl/mob_mat_store.sv - N*N element register array with clear-all and N parallel column or row taps
module mob_mat_store
   import mob_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int N        = N_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int AW       = 4,
   parameter int SEL_W    = 2,
   parameter bit ROW_TAPS = 1'b0
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clr,
   input  logic                i_we,
   input  logic [AW-1:0]       i_waddr,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [SEL_W-1:0]    i_sel,
   output logic [N*DATA_W-1:0] o_taps
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem <= '{default: '0};
      end else if (i_clr) begin
         r_mem <= '{default: '0};
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Column taps give slice g = mem[g][sel]; row taps give slice g = mem[sel][g].
   always_comb begin
      o_taps = '0;
      for (int g = 0; g < N; g++) begin
         if (ROW_TAPS) begin
            o_taps[g*DATA_W +: DATA_W] = r_mem[AW'(32'(i_sel) * N + g)];
         end else begin
            o_taps[g*DATA_W +: DATA_W] = r_mem[AW'(g * N + 32'(i_sel))];
         end
      end
   end

endmodule

// File: rtl/mat_operand_buffer.sv
// rtl/mat_operand_buffer.sv - loads W then X row-major and streams one W column / X row per beat to the MAC array
module mat_operand_buffer
   import mob_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int N      = N_DEF,
   parameter int DIM_W  = $clog2(N + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clear,
   input  logic                i_start,
   input  logic [DIM_W-1:0]    i_rows_w,
   input  logic [DIM_W-1:0]    i_cols_w,
   input  logic [DIM_W-1:0]    i_rows_x,
   input  logic [DIM_W-1:0]    i_cols_x,
   input  logic                i_in_valid,
   input  logic [DATA_W-1:0]   i_in_data,
   output logic                o_in_ready,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [N*DATA_W-1:0] o_out_w,
   output logic [N*DATA_W-1:0] o_out_x,
   output logic                o_out_last,
   output logic                o_mac_clear,
   output logic                o_busy,
   output logic                o_err
);

   localparam int DEPTH = N * N;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t              r_state;
   logic [DIM_W-1:0]    r_rw, r_cw, r_rx, r_cx;
   logic [DIM_W-1:0]    r_row, r_col, r_k;
   logic                r_in_ready, r_out_valid, r_out_last, r_mac_clear, r_busy, r_err;

   logic                w_start_ok, w_dims_bad, w_accept, w_xfer;
   logic                w_row_end, w_mat_end, w_mem_clr, w_we_w, w_we_x;
   logic [DIM_W-1:0]    w_rows, w_cols;
   logic [AW-1:0]       w_waddr;
   logic [N*DATA_W-1:0] w_taps_w, w_taps_x;

   assign w_start_ok = i_start && !i_clear && ((r_state == IDLE) || (r_state == DONE));
   assign w_dims_bad = dims_err(32'(i_rows_w), 32'(i_cols_w), 32'(i_rows_x), 32'(i_cols_x), N);
   assign w_accept   = i_in_valid && r_in_ready;
   assign w_xfer     = r_out_valid && i_out_ready;

   // One shared row/column walker serves both load phases; bounds switch with the phase.
   assign w_rows    = (r_state == LOAD_X) ? r_rx : r_rw;
   assign w_cols    = (r_state == LOAD_X) ? r_cx : r_cw;
   assign w_row_end = (r_col == w_cols - DIM_W'(1));
   assign w_mat_end = w_row_end && (r_row == w_rows - DIM_W'(1));
   assign w_waddr   = AW'(r_row) * AW'(N) + AW'(r_col);

   assign w_mem_clr = i_clear || (w_start_ok && !w_dims_bad);
   assign w_we_w    = w_accept && (r_state == LOAD_W);
   assign w_we_x    = w_accept && (r_state == LOAD_X);

   mob_mat_store #(
      .DATA_W(DATA_W), .N(N), .DEPTH(DEPTH), .AW(AW), .SEL_W(DIM_W), .ROW_TAPS(1'b0)
   ) u_store_w (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_mem_clr), .i_we(w_we_w),
      .i_waddr(w_waddr), .i_wdata(i_in_data), .i_sel(r_k), .o_taps(w_taps_w)
   );

   mob_mat_store #(
      .DATA_W(DATA_W), .N(N), .DEPTH(DEPTH), .AW(AW), .SEL_W(DIM_W), .ROW_TAPS(1'b1)
   ) u_store_x (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_mem_clr), .i_we(w_we_x),
      .i_waddr(w_waddr), .i_wdata(i_in_data), .i_sel(r_k), .o_taps(w_taps_x)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_rw        <= '0;
         r_cw        <= '0;
         r_rx        <= '0;
         r_cx        <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_k         <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_mac_clear <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else if (i_clear) begin
         r_state     <= IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_k         <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_mac_clear <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mac_clear <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (w_start_ok) begin
                  if (w_dims_bad) begin
                     r_err   <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_err      <= 1'b0;
                     r_rw       <= i_rows_w;
                     r_cw       <= i_cols_w;
                     r_rx       <= i_rows_x;
                     r_cx       <= i_cols_x;
                     r_row      <= '0;
                     r_col      <= '0;
                     r_k        <= '0;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= LOAD_W;
                  end
               end
            end
            LOAD_W, LOAD_X: begin
               if (w_accept) begin
                  if (w_row_end) begin
                     r_col <= '0;
                     r_row <= w_mat_end ? '0 : r_row + DIM_W'(1);
                  end else begin
                     r_col <= r_col + DIM_W'(1);
                  end
                  if (w_mat_end) begin
                     if (r_state == LOAD_W) begin
                        r_state <= LOAD_X;
                     end else begin
                        r_state     <= STREAM;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_mac_clear <= 1'b1;
                        r_k         <= '0;
                        r_out_last  <= (r_cw == DIM_W'(1));
                     end
                  end
               end
            end
            STREAM: begin
               if (w_xfer) begin
                  if (r_out_last) begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_busy      <= 1'b0;
                  end else begin
                     r_k        <= r_k + DIM_W'(1);
                     r_out_last <= (r_k + DIM_W'(2) == r_cw);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_last  = r_out_last;
   assign o_mac_clear = r_mac_clear;
   assign o_busy      = r_busy;
   assign o_err       = r_err;
   assign o_out_w     = r_out_valid ? w_taps_w : '0;
   assign o_out_x     = r_out_valid ? w_taps_x : '0;

endmodule

// File: tb/tb_mat_operand_buffer.sv
// tb/tb_mat_operand_buffer.sv - randomized self-checking bench for mat_operand_buffer against a matrix model
module tb_mat_operand_buffer;

   localparam int DW    = 4;
   localparam int N     = 3;
   localparam int DIM_W = 2;

   logic            i_clk = 1'b0;
   logic            i_rst_n, i_clear, i_start, i_in_valid, i_out_ready;
   logic [DIM_W-1:0] i_rows_w, i_cols_w, i_rows_x, i_cols_x;
   logic [DW-1:0]   i_in_data;
   logic            o_in_ready, o_out_valid, o_out_last, o_mac_clear, o_busy, o_err;
   logic [N*DW-1:0] o_out_w, o_out_x;

   int n_pass = 0;
   int n_total = 0;
   int m_rw, m_cw, m_rx, m_cx;
   int mw [N][N];
   int mx [N][N];

   always #5 i_clk = ~i_clk;

   mat_operand_buffer #(.DATA_W(DW), .N(N), .DIM_W(DIM_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_start(i_start),
      .i_rows_w(i_rows_w), .i_cols_w(i_cols_w), .i_rows_x(i_rows_x), .i_cols_x(i_cols_x),
      .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_w(o_out_w), .o_out_x(o_out_x),
      .o_out_last(o_out_last), .o_mac_clear(o_mac_clear), .o_busy(o_busy), .o_err(o_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // W column k padded to N rows, and X row k padded to N columns.
   function automatic logic [N*DW-1:0] exp_w(input int k);
      logic [N*DW-1:0] v = '0;
      for (int i = 0; i < N; i++) if (i < m_rw) v[i*DW +: DW] = 4'(mw[i][k]);
      return v;
   endfunction

   function automatic logic [N*DW-1:0] exp_x(input int k);
      logic [N*DW-1:0] v = '0;
      for (int j = 0; j < N; j++) if (j < m_cx) v[j*DW +: DW] = 4'(mx[k][j]);
      return v;
   endfunction

   task automatic set_dims(input int rw, input int cw, input int rx, input int cx);
      m_rw = rw; m_cw = cw; m_rx = rx; m_cx = cx;
   endtask

   task automatic rand_fill();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            mw[i][j] = int'($urandom_range(0, 15));
            mx[i][j] = int'($urandom_range(0, 15));
         end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"}, 32'(o_in_ready), 0);
      chk({tag, "_out_valid"}, 32'(o_out_valid), 0);
      chk({tag, "_out_w"}, 32'(o_out_w), 0);
      chk({tag, "_out_x"}, 32'(o_out_x), 0);
      chk({tag, "_out_last"}, 32'(o_out_last), 0);
      chk({tag, "_mac_clear"}, 32'(o_mac_clear), 0);
      chk({tag, "_busy"}, 32'(o_busy), 0);
   endtask

   task automatic do_start(input int rw, input int cw, input int rx, input int cx);
      i_rows_w = DIM_W'(rw); i_cols_w = DIM_W'(cw);
      i_rows_x = DIM_W'(rx); i_cols_x = DIM_W'(cx);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] d, input bit gap);
      int t = 0;
      if (gap) begin
         i_in_valid = 1'b0;
         i_in_data  = 4'($urandom);
         @(negedge i_clk);
      end
      i_in_valid = 1'b1;
      i_in_data  = d;
      while (!o_in_ready && t < 20) begin
         @(negedge i_clk);
         t++;
      end
      if (t >= 20) chk("in_ready_timeout", 32'(o_in_ready), 1);
      @(negedge i_clk);
      i_in_valid = 1'b0;
   endtask

   task automatic load(input bit gap);
      do_start(m_rw, m_cw, m_rx, m_cx);
      chk("start_busy", 32'(o_busy), 1);
      chk("start_err", 32'(o_err), 0);
      chk("start_in_ready", 32'(o_in_ready), 1);
      for (int r = 0; r < m_rw; r++)
         for (int c = 0; c < m_cw; c++) push(4'(mw[r][c]), gap);
      for (int r = 0; r < m_rx; r++)
         for (int c = 0; c < m_cx; c++) push(4'(mx[r][c]), gap);
   endtask

   task automatic run_stream(input int stall_beat, input int stall_len, input bit rnd);
      int k = 0;
      int t = 0;
      int stalled = 0;
      while (k < m_cw && t < 100) begin
         chk("out_valid", 32'(o_out_valid), 1);
         chk("out_w", 32'(o_out_w), 32'(exp_w(k)));
         chk("out_x", 32'(o_out_x), 32'(exp_x(k)));
         chk("out_last", 32'(o_out_last), 32'(k == m_cw - 1));
         chk("mac_clear", 32'(o_mac_clear), 32'(t == 0));
         chk("stream_in_ready", 32'(o_in_ready), 0);
         if (k == stall_beat && stalled < stall_len) begin
            i_out_ready = 1'b0;
            stalled++;
         end else begin
            i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(negedge i_clk);
         t++;
         if (i_out_ready) k++;
      end
      i_out_ready = 1'b0;
      chk("stream_beats", 32'(k), 32'(m_cw));
      if (!rnd) chk("stream_cycles", 32'(t), 32'(m_cw + stall_len));
      chk("done_out_valid", 32'(o_out_valid), 0);
      chk("done_out_last", 32'(o_out_last), 0);
      chk("done_busy", 32'(o_busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      i_rst_n = 1'b0; i_clear = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
      i_in_data = '0; i_rows_w = '0; i_cols_w = '0; i_rows_x = '0; i_cols_x = '0;
      repeat (3) @(negedge i_clk);
      check_idle("reset");
      chk("reset_err", 32'(o_err), 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check_idle("post_reset");

      set_dims(3, 3, 3, 3);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            mw[i][j] = i * 3 + j + 1;
            mx[i][j] = 9 - (i * 3 + j);
         end
      load(1'b0);
      chk("nom_b0_w", 32'(o_out_w), 32'h741);
      chk("nom_b0_x", 32'(o_out_x), 32'h789);
      run_stream(-1, 0, 1'b0);

      set_dims(2, 3, 3, 1);
      rand_fill();
      for (int j = 0; j < 3; j++) begin
         mw[0][j] = j + 1;
         mw[1][j] = j + 4;
         mx[j][0] = j + 2;
      end
      load(1'b1);
      chk("ns_b0_w", 32'(o_out_w), 32'h041);
      chk("ns_b0_x", 32'(o_out_x), 32'h002);
      run_stream(-1, 0, 1'b0);

      set_dims(3, 3, 3, 3);
      rand_fill();
      load(1'b0);
      run_stream(1, 4, 1'b0);

      set_dims(3, 2, 2, 3);
      rand_fill();
      load(1'b0);
      run_stream(-1, 0, 1'b0);
      load(1'b1);
      run_stream(-1, 0, 1'b0);

      repeat (6) begin
         int cw;
         cw = int'($urandom_range(1, 3));
         set_dims(int'($urandom_range(1, 3)), cw, cw, int'($urandom_range(1, 3)));
         rand_fill();
         load(1'($urandom_range(0, 1)));
         run_stream(-1, 0, 1'b1);
      end

      do_start(2, 2, 3, 2);
      chk("dim_err", 32'(o_err), 1);
      check_idle("dim_err");
      i_in_valid = 1'b1;
      i_in_data  = 4'hf;
      repeat (2) @(negedge i_clk);
      chk("dim_err_in_ready", 32'(o_in_ready), 0);
      chk("dim_err_busy", 32'(o_busy), 0);
      i_in_valid = 1'b0;
      do_start(0, 1, 1, 1);
      chk("zero_dim_err", 32'(o_err), 1);
      set_dims(1, 1, 1, 1);
      rand_fill();
      load(1'b0);
      run_stream(-1, 0, 1'b0);
      do_start(1, 3, 2, 1);
      chk("dim_err2", 32'(o_err), 1);
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      chk("clear_err", 32'(o_err), 0);

      set_dims(3, 3, 3, 3);
      rand_fill();
      do_start(3, 3, 3, 3);
      for (int e = 0; e < 9; e++) push(4'(mw[e / 3][e % 3]), 1'b0);
      push(4'(mx[0][0]), 1'b0);
      push(4'(mx[0][1]), 1'b0);
      chk("mid_x_busy", 32'(o_busy), 1);
      chk("mid_x_in_ready", 32'(o_in_ready), 1);
      #2 i_rst_n = 1'b0;
      #1 check_idle("rst_mid");
      chk("rst_mid_err", 32'(o_err), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check_idle("rst_after");
      set_dims(2, 2, 2, 1);
      rand_fill();
      load(1'b0);
      run_stream(-1, 0, 1'b0);

      set_dims(3, 2, 2, 2);
      rand_fill();
      load(1'b0);
      chk("pre_clear_valid", 32'(o_out_valid), 1);
      @(negedge i_clk);
      chk("pre_clear_hold_w", 32'(o_out_w), 32'(exp_w(0)));
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      check_idle("clear_stream");

      i_rows_w = 2'd2; i_cols_w = 2'd2; i_rows_x = 2'd2; i_cols_x = 2'd2;
      i_clear = 1'b1;
      i_start = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      i_start = 1'b0;
      check_idle("clear_start");
      @(negedge i_clk);
      check_idle("clear_start2");
      chk("clear_start_err", 32'(o_err), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
